change_payout: RTL
==================

CHANGE_PAYOUT -- requirements
Module: change_payout

Interface
REQ-001 Parameter PULSE_CYCLES, 4: cycles coin_out is held per coin (>=1).
REQ-002 Parameter GAP_CYCLES, 2: idle cycles between coins (>=1).
REQ-003 Parameter ACK_TIMEOUT, 16: max cycles waiting for coin_ack.
REQ-004 Parameter INV_W, 6: width of each coin stock counter.
REQ-005 Parameter INIT_STOCK, 0: stock value of both tubes after reset.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 pay_valid  in  1  change request valid.
REQ-009 pay_amt  in  5  change owed, in 5rs units.
REQ-010 pay_ready  out  1  request accepted when pay_valid && pay_ready.
REQ-011 coin_out  out  2  hopper drive: 2'b10 = 10rs, 2'b01 = 5rs, 2'b00 = none.
REQ-012 coin_ack  in  1  hopper confirms coin dropped.
REQ-013 refill_valid / refill_10 / refill_5  in  1 / INV_W / INV_W  stock top-up.
REQ-014 busy / done / short / fault  out  1 each  active job / 1-cycle completion pulse / unpaid remainder flag / hopper timeout.
REQ-015 remain  out  5  amount still owed, in 5rs units.
REQ-016 stock_10 / stock_5  out  INV_W each  coins held per tube.

Function
REQ-017 States: IDLE, SELECT, PULSE, WAIT_ACK, GAP, DONE, FAULT; pay_ready=1 only in IDLE; busy=1 in all states except IDLE and FAULT.
REQ-018 Handshake in IDLE loads remain<=pay_amt and moves to SELECT; the first coin_out is asserted two cycles after the handshake cycle.
REQ-019 SELECT is greedy: remain>=2 and stock_10>0 -> 10rs; else remain>=1 and stock_5>0 -> 5rs; else -> DONE.
REQ-020 PULSE drives the chosen code for exactly PULSE_CYCLES cycles, then WAIT_ACK with coin_out=00.
REQ-021 WAIT_ACK: coin_ack decrements remain by 2 or 1 and the matching stock by 1, then GAP; coin_ack is ignored in all other states.
REQ-022 No coin_ack within ACK_TIMEOUT cycles -> FAULT: fault=1, coin_out=00, pay_ready=0, held until rst.
REQ-023 GAP lasts GAP_CYCLES cycles, then SELECT.
REQ-024 DONE asserts done for one cycle with short=(remain!=0); remain holds its value until the next handshake; next state IDLE.
REQ-025 pay_amt=0: SELECT goes straight to DONE, no coin driven, short=0.
REQ-026 Refill is accepted in IDLE only and adds to each stock saturating at 2^INV_W-1; a refill and a handshake in the same cycle are both honoured, and SELECT sees the refilled stock.
REQ-027 All arithmetic is unsigned and remain never underflows: 10rs is never chosen when remain<2.

Reset
REQ-028 rst at any edge, including mid-coin: next state IDLE, coin_out=00, remain=0, done/short/fault/busy=0, pay_ready=1, stock_10=stock_5=INIT_STOCK.

Configuration
REQ-029 With COIN_INVENTORY_EN defined: stock is tracked and refilled as above, and short can assert.
REQ-030 Without COIN_INVENTORY_EN: both tubes are treated as unlimited, stock outputs are tied to 0, refill inputs are ignored, short is always 0, and SELECT chooses 10rs whenever remain>=2.

Structure
REQ-031 Shared package vend_pkg holds the coin codes (COIN_NONE, COIN_5, COIN_10), coin values in 5rs units, and the state enum.
REQ-032 One sub-module, payout_timer: a loadable down-counter reused for the PULSE, GAP and ACK timeout intervals.

Verification (PULSE_CYCLES=4, GAP_CYCLES=2, ACK_TIMEOUT=16, macro on unless stated)
REQ-033 Stock 10/10, pay_amt=7, each coin acked -> coin_out sequence 10,10,10,01; done with short=0, remain=0, stock_10=7, stock_5=9.
REQ-034 stock_10=0, stock_5=3, pay_amt=5 -> three 01 coins; done with short=1, remain=2, stock_5=0.
REQ-035 pay_amt=0 -> done pulse, coin_out stays 00, pay_ready back to 1 after DONE.
REQ-036 coin_ack withheld after the first pulse -> fault=1 after 16 WAIT_ACK cycles, coin_out=00, pay_ready=0 until rst.
REQ-037 rst during the PULSE of the 2nd coin -> next cycle coin_out=00, state IDLE, pay_ready=1, both stocks equal INIT_STOCK.
REQ-038 Macro off, pay_amt=3 -> coin_out 10 then 01; stock outputs 0, short=0.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes, coin values and payout state encoding
//
// Purpose : common definitions for the change payout block.
//   COIN_NONE / COIN_5 / COIN_10 : hopper drive codes
//   VAL_5 / VAL_10               : coin values in 5rs units
//   state_t                      : payout controller states
//   coin_value()                 : drive code -> value in 5rs units
package vend_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   localparam logic [4:0] VAL_5  = 5'd1;
   localparam logic [4:0] VAL_10 = 5'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_PULSE,
      ST_WAIT_ACK,
      ST_GAP,
      ST_DONE,
      ST_FAULT
   } state_t;

   function automatic logic [4:0] coin_value(input logic [1:0] coin);
      case (coin)
         COIN_10: coin_value = VAL_10;
         COIN_5:  coin_value = VAL_5;
         default: coin_value = 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/payout_timer.sv
// rtl/payout_timer.sv - loadable down-counter for pulse, gap and ack timeout intervals
//
// Purpose : counts down from a loaded value to zero and holds there.
// Ports   :
//   i_clk      in  clock, rising edge
//   i_rst      in  synchronous active-high reset (clears count)
//   i_load     in  load i_load_val this cycle (has priority over counting)
//   i_load_val in  W  value to load; an interval of N cycles loads N-1
//   o_zero     out count has reached zero
module payout_timer #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/change_payout.sv
// rtl/change_payout.sv - greedy 10rs/5rs change dispenser driving a coin hopper
//
// Purpose : accepts a change request, pays it out coin by coin (10rs first),
//           waits for a hopper ack per coin and flags timeouts.
// Build option: COIN_INVENTORY_EN - track/refill per-tube stock and report
//           short payouts; when undefined both tubes are unlimited.
// Ports   :
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_pay_valid, i_pay_amt[4:0]       change request (5rs units)
//   o_pay_ready                       request accepted in IDLE
//   o_coin_out[1:0]                   hopper drive (10=10rs, 01=5rs, 00=none)
//   i_coin_ack                        hopper confirms a coin dropped
//   i_refill_valid, i_refill_10/5     stock top-up (IDLE only)
//   o_busy, o_done, o_short, o_fault  status
//   o_remain[4:0]                     amount still owed
//   o_stock_10, o_stock_5             coins held per tube
module change_payout
   import vend_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 2,
   parameter int ACK_TIMEOUT  = 16,
   parameter int INV_W        = 6,
   parameter int INIT_STOCK   = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pay_valid,
   input  logic [4:0]       i_pay_amt,
   output logic             o_pay_ready,
   output logic [1:0]       o_coin_out,
   input  logic             i_coin_ack,
   input  logic             i_refill_valid,
   input  logic [INV_W-1:0] i_refill_10,
   input  logic [INV_W-1:0] i_refill_5,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_short,
   output logic             o_fault,
   output logic [4:0]       o_remain,
   output logic [INV_W-1:0] o_stock_10,
   output logic [INV_W-1:0] o_stock_5
);

   localparam int TW = $clog2(PULSE_CYCLES + GAP_CYCLES + ACK_TIMEOUT + 1);

   state_t        r_state;
   state_t        w_next;
   logic [4:0]    r_remain;
   logic [1:0]    r_coin;
   logic [1:0]    w_sel;
   logic          w_has_10;
   logic          w_has_5;
   logic          w_tmr_load;
   logic [TW-1:0] w_tmr_val;
   logic          w_tmr_zero;
   logic          w_ack_take;

   assign w_ack_take = (r_state == ST_WAIT_ACK) && i_coin_ack;

`ifdef COIN_INVENTORY_EN
   logic [INV_W-1:0] r_stock_10;
   logic [INV_W-1:0] r_stock_5;
   logic [INV_W:0]   w_sum_10;
   logic [INV_W:0]   w_sum_5;

   // One extra bit catches the carry so the top-up can saturate.
   assign w_sum_10 = {1'b0, r_stock_10} + {1'b0, i_refill_10};
   assign w_sum_5  = {1'b0, r_stock_5}  + {1'b0, i_refill_5};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stock_10 <= INV_W'(INIT_STOCK);
         r_stock_5  <= INV_W'(INIT_STOCK);
      end else if ((r_state == ST_IDLE) && i_refill_valid) begin
         r_stock_10 <= w_sum_10[INV_W] ? '1 : w_sum_10[INV_W-1:0];
         r_stock_5  <= w_sum_5[INV_W]  ? '1 : w_sum_5[INV_W-1:0];
      end else if (w_ack_take) begin
         if (r_coin == COIN_10) r_stock_10 <= r_stock_10 - 1'b1;
         if (r_coin == COIN_5)  r_stock_5  <= r_stock_5 - 1'b1;
      end
   end

   assign w_has_10   = (r_stock_10 != '0);
   assign w_has_5    = (r_stock_5 != '0);
   assign o_stock_10 = r_stock_10;
   assign o_stock_5  = r_stock_5;
   assign o_short    = o_done && (r_remain != 5'd0);
`else
   logic w_unused_refill;
   assign w_unused_refill = ^{i_refill_valid, i_refill_10, i_refill_5};
   assign w_has_10   = 1'b1;
   assign w_has_5    = 1'b1;
   assign o_stock_10 = '0;
   assign o_stock_5  = '0;
   assign o_short    = 1'b0;
`endif

   // Greedy pick; the remain checks keep remain from ever underflowing.
   always_comb begin
      w_sel = COIN_NONE;
      if ((r_remain >= VAL_10) && w_has_10) begin
         w_sel = COIN_10;
      end else if ((r_remain >= VAL_5) && w_has_5) begin
         w_sel = COIN_5;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_remain <= 5'd0;
         r_coin   <= COIN_NONE;
      end else begin
         r_state <= w_next;
         if ((r_state == ST_IDLE) && i_pay_valid) r_remain <= i_pay_amt;
         if (r_state == ST_SELECT) r_coin <= w_sel;
         if (w_ack_take) r_remain <= r_remain - coin_value(r_coin);
      end
   end

   always_comb begin
      w_next      = r_state;
      o_pay_ready = 1'b0;
      o_busy      = 1'b1;
      o_done      = 1'b0;
      o_fault     = 1'b0;
      o_coin_out  = COIN_NONE;
      case (r_state)
         ST_IDLE: begin
            o_pay_ready = 1'b1;
            o_busy      = 1'b0;
            if (i_pay_valid) w_next = ST_SELECT;
         end
         ST_SELECT: begin
            w_next = (w_sel == COIN_NONE) ? ST_DONE : ST_PULSE;
         end
         ST_PULSE: begin
            o_coin_out = r_coin;
            if (w_tmr_zero) w_next = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // An ack on the last allowed cycle still counts.
            if (i_coin_ack) w_next = ST_GAP;
            else if (w_tmr_zero) w_next = ST_FAULT;
         end
         ST_GAP: begin
            if (w_tmr_zero) w_next = ST_SELECT;
         end
         ST_DONE: begin
            o_done = 1'b1;
            w_next = ST_IDLE;
         end
         ST_FAULT: begin
            o_busy  = 1'b0;
            o_fault = 1'b1;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // The timer is reloaded on every state change with the length of the
   // state being entered, minus one because the entry cycle counts.
   always_comb begin
      w_tmr_load = (w_next != r_state);
      w_tmr_val  = '0;
      case (w_next)
         ST_PULSE:    w_tmr_val = TW'(PULSE_CYCLES - 1);
         ST_WAIT_ACK: w_tmr_val = TW'(ACK_TIMEOUT - 1);
         ST_GAP:      w_tmr_val = TW'(GAP_CYCLES - 1);
         default:     w_tmr_val = '0;
      endcase
   end

   payout_timer #(
      .W(TW)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   assign o_remain = r_remain;

endmodule
